segment_scan_ctrl: RTL



---
 rtl/segment_scan_ctrl.sv | 124 ++++++++++++
 1 files changed

// File: rtl/segment_scan_ctrl.sv
// segment_scan_ctrl: frame-snapshotting digit scanner with guard blanking.
// Define SCAN_BLINK_EN to build the blink-phase logic and honor blink_mask.
module segment_scan_ctrl #(
  parameter int DIGITS       = 4,
  parameter int PRESCALE     = 50000,
  parameter int GUARD        = 16,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [4*DIGITS-1:0] digits_in,
  input  logic [DIGITS-1:0]   blank_mask,
  input  logic [DIGITS-1:0]   blink_mask,
  output logic [3:0]          bcd,
  output logic                enable,
  output logic [DIGITS-1:0]   digit_sel,
  output logic                frame_done,
  output logic                blink_phase
);

  localparam int DW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(PRESCALE - 1);
  localparam logic [DW-1:0] DIV_GRD = DW'(GUARD);
  localparam logic [IW-1:0] IDX_MAX = IW'(DIGITS - 1);

  typedef enum logic {
    SLOT_GUARD,
    SLOT_SHOW
  } slot_e;

  logic [DW-1:0]          div_q;
  logic [DW-1:0]          div_d;
  logic [IW-1:0]          idx_q;
  logic [IW-1:0]          idx_d;
  logic [DIGITS-1:0][3:0] dig_q;
  logic [DIGITS-1:0]      blank_q;
  logic                   done_q;
  logic                   boot_q;
  logic                   slot_end;
  logic                   frame_end;
  logic                   blink_off;
  slot_e                  slot;

  always_comb begin
    slot_end  = (div_q == DIV_MAX);
    frame_end = slot_end && (idx_q == IDX_MAX);
    div_d     = slot_end ? '0 : div_q + 1'b1;
    idx_d     = idx_q;
    if (slot_end) begin
      idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q   <= '0;
      idx_q   <= '0;
      dig_q   <= '0;
      blank_q <= '0;
      done_q  <= 1'b0;
      boot_q  <= 1'b1;
    end else begin
      div_q  <= div_d;
      idx_q  <= idx_d;
      done_q <= frame_end;
      boot_q <= 1'b0;
      if (frame_end) begin
        dig_q   <= digits_in;
        blank_q <= blank_mask;
      end
    end
  end

`ifdef SCAN_BLINK_EN
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FW-1:0] FRM_MAX = FW'(BLINK_FRAMES - 1);

  logic [FW-1:0]     frm_q;
  logic [DIGITS-1:0] blink_q;
  logic              phase_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frm_q   <= '0;
      blink_q <= '0;
      phase_q <= 1'b0;
    end else if (frame_end) begin
      blink_q <= blink_mask;
      if (frm_q == FRM_MAX) begin
        frm_q   <= '0;
        phase_q <= ~phase_q;
      end else begin
        frm_q <= frm_q + 1'b1;
      end
    end
  end

  assign blink_phase = phase_q;
  assign blink_off   = blink_q[idx_q] & phase_q;
`else
  logic blink_unused;
  assign blink_unused = ^{blink_mask, BLINK_FRAMES[0]};
  assign blink_phase  = 1'b0;
  assign blink_off    = 1'b0;
`endif

  assign slot = (div_q < DIV_GRD) ? SLOT_GUARD : SLOT_SHOW;

  // Post-reset first cycle opens a frame but no frame-end edge preceded it.
  assign frame_done = done_q | (boot_q & reset_n);

  always_comb begin
    bcd       = 4'h0;
    enable    = 1'b0;
    digit_sel = '0;
    if (slot == SLOT_SHOW) begin
      digit_sel = DIGITS'(1) << idx_q;
      bcd       = dig_q[idx_q];
      enable    = ~(blank_q[idx_q] | blink_off);
    end
  end

endmodule
